// File: rtl/ysyx_lsu_sq_pkg.sv
// Shared LSU store-queue types: drain engine states and default queue depth.
package ysyx_lsu_sq_pkg;

    localparam int unsigned SQ_SIZE_DEFAULT = 4;

    typedef enum logic [1:0] {
        SQ_IDLE = 2'd0,
        SQ_REQ  = 2'd1,
        SQ_RESP = 2'd2
    } sq_drain_e;

endpackage

// File: rtl/ysyx_lsu_sq_fwd.sv
// Combinational store-to-load forwarding: per byte lane, the youngest valid
// word-matching entry with its strobe set supplies the byte.
module ysyx_lsu_sq_fwd
    import ysyx_lsu_sq_pkg::*;
#(
    parameter  int unsigned SQ_SIZE = SQ_SIZE_DEFAULT,
    parameter  int unsigned XLEN    = 32,
    localparam int unsigned PW      = $clog2(SQ_SIZE),
    localparam int unsigned NB      = XLEN / 8
)(
    input  logic [XLEN-1:0]    i_addr [SQ_SIZE],
    input  logic [XLEN-1:0]    i_data [SQ_SIZE],
    input  logic [NB-1:0]      i_strb [SQ_SIZE],
    input  logic [SQ_SIZE-1:0] i_valid,
    input  logic [PW-1:0]      i_head,
    input  logic [XLEN-1:0]    i_ld_addr,
    input  logic [NB-1:0]      i_ld_strb,
    output logic [XLEN-1:0]    o_fwd_data,
    output logic [NB-1:0]      o_covered
);

    localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

    logic [XLEN-1:0] w_merged;
    logic [NB-1:0]   w_supplied;
    logic [PW-1:0]   w_idx;

    // Walk oldest (head) to youngest so later matches overwrite earlier ones.
    always_comb begin
        w_merged   = '0;
        w_supplied = '0;
        w_idx      = '0;
        for (int unsigned k = 0; k < SQ_SIZE; k++) begin
            w_idx = i_head + PW'(k);
            if (i_valid[w_idx] && (((i_addr[w_idx] ^ i_ld_addr) & WORD_MASK) == '0)) begin
                for (int unsigned b = 0; b < NB; b++) begin
                    if (i_strb[w_idx][b]) begin
                        w_merged[8*b +: 8] = i_data[w_idx][8*b +: 8];
                        w_supplied[b]      = 1'b1;
                    end
                end
            end
        end
    end

    assign o_covered = w_supplied & i_ld_strb;

    always_comb begin
        o_fwd_data = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            if (o_covered[b]) begin
                o_fwd_data[8*b +: 8] = w_merged[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/ysyx_lsu_sq.sv
// Store queue: circular buffer of committed stores, byte-granular forwarding,
// and a single-outstanding IDLE/REQ/RESP write-drain engine.
module ysyx_lsu_sq
    import ysyx_lsu_sq_pkg::*;
#(
    parameter  int unsigned SQ_SIZE = SQ_SIZE_DEFAULT,
    parameter  int unsigned XLEN    = 32,
    localparam int unsigned PW      = $clog2(SQ_SIZE),
    localparam int unsigned CW      = $clog2(SQ_SIZE) + 1,
    localparam int unsigned NB      = XLEN / 8
)(
    input  logic            clock,
    input  logic            reset,
    input  logic            commit_valid,
    output logic            commit_ready,
    input  logic [XLEN-1:0] commit_addr,
    input  logic [XLEN-1:0] commit_data,
    input  logic [NB-1:0]   commit_strb,
    input  logic            ld_valid,
    input  logic [XLEN-1:0] ld_addr,
    input  logic [NB-1:0]   ld_strb,
    output logic            fwd_hit,
    output logic            fwd_stall,
    output logic [XLEN-1:0] fwd_data,
    output logic            bus_awvalid,
    output logic [XLEN-1:0] bus_awaddr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [NB-1:0]   bus_wstrb,
    input  logic            bus_wready,
    input  logic            bus_bvalid,
    output logic            sq_empty,
    output logic [CW-1:0]   sq_count
);

    logic [XLEN-1:0]    r_addr [SQ_SIZE];
    logic [XLEN-1:0]    r_data [SQ_SIZE];
    logic [NB-1:0]      r_strb [SQ_SIZE];
    logic [PW-1:0]      r_head;
    logic [PW-1:0]      r_tail;
    logic [CW-1:0]      r_count;
    sq_drain_e          r_state;
    sq_drain_e          w_state_nxt;
    logic               w_push;
    logic               w_pop;
    logic [SQ_SIZE-1:0] w_valid;
    logic [PW-1:0]      w_off;
    logic [NB-1:0]      w_covered;

    assign commit_ready = (r_count != CW'(SQ_SIZE));
    assign w_push       = commit_valid && commit_ready;
    assign w_pop        = (r_state == SQ_RESP) && bus_bvalid;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_addr[r_tail] <= commit_addr;
            r_data[r_tail] <= commit_data;
            r_strb[r_tail] <= commit_strb;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + PW'(1);
            if (w_pop)  r_head <= r_head + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= SQ_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        bus_awvalid = 1'b0;
        case (r_state)
            SQ_IDLE: if (r_count != '0) w_state_nxt = SQ_REQ;
            SQ_REQ: begin
                bus_awvalid = 1'b1;
                if (bus_wready) w_state_nxt = SQ_RESP;
            end
            SQ_RESP: if (bus_bvalid) w_state_nxt = SQ_IDLE;
            default: w_state_nxt = SQ_IDLE;
        endcase
    end

    // Bus fields read as zero whenever no request is being offered.
    assign bus_awaddr = bus_awvalid ? r_addr[r_head] : '0;
    assign bus_wdata  = bus_awvalid ? r_data[r_head] : '0;
    assign bus_wstrb  = bus_awvalid ? r_strb[r_head] : '0;

    always_comb begin
        w_valid = '0;
        w_off   = '0;
        for (int unsigned i = 0; i < SQ_SIZE; i++) begin
            w_off      = PW'(i) - r_head;
            w_valid[i] = ({1'b0, w_off} < r_count);
        end
    end

    ysyx_lsu_sq_fwd #(
        .SQ_SIZE (SQ_SIZE),
        .XLEN    (XLEN)
    ) u_fwd (
        .i_addr     (r_addr),
        .i_data     (r_data),
        .i_strb     (r_strb),
        .i_valid    (w_valid),
        .i_head     (r_head),
        .i_ld_addr  (ld_addr),
        .i_ld_strb  (ld_strb),
        .o_fwd_data (fwd_data),
        .o_covered  (w_covered)
    );

    assign fwd_hit   = ld_valid && (w_covered == ld_strb) && (ld_strb != '0);
    assign fwd_stall = ld_valid && (w_covered != '0) && (w_covered != ld_strb);
    assign sq_empty  = (r_count == '0) && (r_state == SQ_IDLE);
    assign sq_count  = r_count;

endmodule

// File: tb/tb_ysyx_lsu_sq.sv
// Directed self-checking bench for ysyx_lsu_sq (SQ_SIZE=4, XLEN=32).
module tb_ysyx_lsu_sq;

    logic        clock = 1'b0;
    logic        reset;
    logic        commit_valid;
    logic        commit_ready;
    logic [31:0] commit_addr;
    logic [31:0] commit_data;
    logic [3:0]  commit_strb;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [3:0]  ld_strb;
    logic        fwd_hit;
    logic        fwd_stall;
    logic [31:0] fwd_data;
    logic        bus_awvalid;
    logic [31:0] bus_awaddr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_wready;
    logic        bus_bvalid;
    logic        sq_empty;
    logic [2:0]  sq_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    ysyx_lsu_sq #(
        .SQ_SIZE (4),
        .XLEN    (32)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .commit_valid (commit_valid),
        .commit_ready (commit_ready),
        .commit_addr  (commit_addr),
        .commit_data  (commit_data),
        .commit_strb  (commit_strb),
        .ld_valid     (ld_valid),
        .ld_addr      (ld_addr),
        .ld_strb      (ld_strb),
        .fwd_hit      (fwd_hit),
        .fwd_stall    (fwd_stall),
        .fwd_data     (fwd_data),
        .bus_awvalid  (bus_awvalid),
        .bus_awaddr   (bus_awaddr),
        .bus_wdata    (bus_wdata),
        .bus_wstrb    (bus_wstrb),
        .bus_wready   (bus_wready),
        .bus_bvalid   (bus_bvalid),
        .sq_empty     (sq_empty),
        .sq_count     (sq_count)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        commit_valid = 1'b1;
        commit_addr  = a;
        commit_data  = d;
        commit_strb  = s;
        tick();
        commit_valid = 1'b0;
    endtask

    task automatic drain_all();
        int cyc;
        cyc = 0;
        bus_wready = 1'b1;
        bus_bvalid = 1'b1;
        while (!sq_empty && cyc < 40) begin
            tick();
            cyc++;
        end
        bus_wready = 1'b0;
        bus_bvalid = 1'b0;
        if (sq_empty !== 1'b1) begin $display("FAIL drain_timeout: sq_empty got %b want 1", sq_empty); n_err++; end n_vec++;
    endtask

    task automatic test_reset();
        reset = 1'b1; commit_valid = 1'b0; commit_addr = '0; commit_data = '0; commit_strb = '0;
        bus_wready = 1'b0; bus_bvalid = 1'b0;
        ld_valid = 1'b1; ld_addr = '0; ld_strb = 4'hF;
        tick(); tick();
        if (commit_ready !== 1'b1) begin $display("FAIL rst_ready: got %b want 1", commit_ready); n_err++; end n_vec++;
        if (sq_empty !== 1'b1) begin $display("FAIL rst_empty: got %b want 1", sq_empty); n_err++; end n_vec++;
        if (sq_count !== 3'd0) begin $display("FAIL rst_count: got %0d want 0", sq_count); n_err++; end n_vec++;
        if (bus_awvalid !== 1'b0) begin $display("FAIL rst_awvalid: got %b want 0", bus_awvalid); n_err++; end n_vec++;
        if (bus_awaddr !== 32'h0) begin $display("FAIL rst_awaddr: got %h want 0", bus_awaddr); n_err++; end n_vec++;
        if (bus_wdata !== 32'h0) begin $display("FAIL rst_wdata: got %h want 0", bus_wdata); n_err++; end n_vec++;
        if (bus_wstrb !== 4'h0) begin $display("FAIL rst_wstrb: got %h want 0", bus_wstrb); n_err++; end n_vec++;
        if (fwd_hit !== 1'b0) begin $display("FAIL rst_hit: got %b want 0", fwd_hit); n_err++; end n_vec++;
        if (fwd_stall !== 1'b0) begin $display("FAIL rst_stall: got %b want 0", fwd_stall); n_err++; end n_vec++;
        reset = 1'b0;
        ld_valid = 1'b0;
    endtask

    task automatic test_single_store();
        push(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
        if (sq_count !== 3'd1) begin $display("FAIL st_count: got %0d want 1", sq_count); n_err++; end n_vec++;
        if (sq_empty !== 1'b0) begin $display("FAIL st_empty_drop: got %b want 0", sq_empty); n_err++; end n_vec++;
        if (bus_awvalid !== 1'b0) begin $display("FAIL st_awvalid_early: got %b want 0", bus_awvalid); n_err++; end n_vec++;
        tick();
        if (bus_awvalid !== 1'b1) begin $display("FAIL st_awvalid: got %b want 1", bus_awvalid); n_err++; end n_vec++;
        if (bus_awaddr !== 32'h8000_0010) begin $display("FAIL st_awaddr: got %h want 80000010", bus_awaddr); n_err++; end n_vec++;
        if (bus_wdata !== 32'hDEAD_BEEF) begin $display("FAIL st_wdata: got %h want deadbeef", bus_wdata); n_err++; end n_vec++;
        if (bus_wstrb !== 4'hF) begin $display("FAIL st_wstrb: got %h want f", bus_wstrb); n_err++; end n_vec++;
        bus_wready = 1'b1;
        tick();
        bus_wready = 1'b0;
        if (bus_awvalid !== 1'b0) begin $display("FAIL st_resp_awvalid: got %b want 0", bus_awvalid); n_err++; end n_vec++;
        if (sq_count !== 3'd1) begin $display("FAIL st_resp_count: got %0d want 1", sq_count); n_err++; end n_vec++;
        bus_bvalid = 1'b1;
        tick();
        bus_bvalid = 1'b0;
        if (sq_empty !== 1'b1) begin $display("FAIL st_empty_rise: got %b want 1", sq_empty); n_err++; end n_vec++;
        if (sq_count !== 3'd0) begin $display("FAIL st_final_count: got %0d want 0", sq_count); n_err++; end n_vec++;
    endtask

    task automatic test_full();
        int k;
        int cyc;
        for (int i = 0; i < 4; i++) push(32'h300 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF);
        if (sq_count !== 3'd4) begin $display("FAIL full_count: got %0d want 4", sq_count); n_err++; end n_vec++;
        if (commit_ready !== 1'b0) begin $display("FAIL full_ready: got %b want 0", commit_ready); n_err++; end n_vec++;
        if (bus_awaddr !== 32'h300) begin $display("FAIL full_awaddr: got %h want 300", bus_awaddr); n_err++; end n_vec++;
        commit_valid = 1'b1; commit_addr = 32'h3F0; commit_data = 32'h55; commit_strb = 4'hF;
        bus_bvalid = 1'b1;
        tick(); tick();
        commit_valid = 1'b0; bus_bvalid = 1'b0;
        if (sq_count !== 3'd4) begin $display("FAIL full_ignore: got %0d want 4", sq_count); n_err++; end n_vec++;
        if (bus_awvalid !== 1'b1) begin $display("FAIL full_awvalid_hold: got %b want 1", bus_awvalid); n_err++; end n_vec++;
        if (bus_awaddr !== 32'h300) begin $display("FAIL full_awaddr_hold: got %h want 300", bus_awaddr); n_err++; end n_vec++;
        if (bus_wdata !== 32'hA0) begin $display("FAIL full_wdata_hold: got %h want a0", bus_wdata); n_err++; end n_vec++;
        bus_wready = 1'b1;
        tick();
        bus_wready = 1'b0;
        if (commit_ready !== 1'b0) begin $display("FAIL full_resp_ready: got %b want 0", commit_ready); n_err++; end n_vec++;
        bus_bvalid = 1'b1;
        tick();
        bus_bvalid = 1'b0;
        if (sq_count !== 3'd3) begin $display("FAIL full_pop_count: got %0d want 3", sq_count); n_err++; end n_vec++;
        if (commit_ready !== 1'b1) begin $display("FAIL full_pop_ready: got %b want 1", commit_ready); n_err++; end n_vec++;
        k = 1; cyc = 0;
        bus_wready = 1'b1; bus_bvalid = 1'b1;
        while (!sq_empty && cyc < 30) begin
            if (bus_awvalid) begin
                if (bus_awaddr !== 32'h300 + 32'(4 * k)) begin $display("FAIL full_order: got %h want %h", bus_awaddr, 32'h300 + 32'(4 * k)); n_err++; end n_vec++;
                k++;
            end
            tick();
            cyc++;
        end
        bus_wready = 1'b0; bus_bvalid = 1'b0;
        if (k !== 4) begin $display("FAIL full_drained: got %0d want 4", k); n_err++; end n_vec++;
        if (sq_empty !== 1'b1) begin $display("FAIL full_empty: got %b want 1", sq_empty); n_err++; end n_vec++;
    endtask

    task automatic test_fwd_youngest();
        push(32'h100, 32'h11, 4'h1);
        push(32'h100, 32'h22, 4'h1);
        ld_valid = 1'b1; ld_addr = 32'h100; ld_strb = 4'h1;
        #1;
        if (fwd_hit !== 1'b1) begin $display("FAIL young_hit: got %b want 1", fwd_hit); n_err++; end n_vec++;
        if (fwd_stall !== 1'b0) begin $display("FAIL young_stall: got %b want 0", fwd_stall); n_err++; end n_vec++;
        if (fwd_data !== 32'h22) begin $display("FAIL young_data: got %h want 22", fwd_data); n_err++; end n_vec++;
        ld_addr = 32'h104;
        #1;
        if (fwd_hit !== 1'b0) begin $display("FAIL miss_hit: got %b want 0", fwd_hit); n_err++; end n_vec++;
        if (fwd_data !== 32'h0) begin $display("FAIL miss_data: got %h want 0", fwd_data); n_err++; end n_vec++;
        ld_valid = 1'b0;
        drain_all();
    endtask

    task automatic test_fwd_merge();
        push(32'h200, 32'h0000_BBAA, 4'h3);
        push(32'h203, 32'hCC00_0000, 4'h8);
        ld_valid = 1'b1; ld_addr = 32'h200; ld_strb = 4'hF;
        #1;
        if (fwd_stall !== 1'b1) begin $display("FAIL merge_stall: got %b want 1", fwd_stall); n_err++; end n_vec++;
        if (fwd_hit !== 1'b0) begin $display("FAIL merge_stall_hit: got %b want 0", fwd_hit); n_err++; end n_vec++;
        ld_strb = 4'hB;
        #1;
        if (fwd_hit !== 1'b1) begin $display("FAIL merge_hit: got %b want 1", fwd_hit); n_err++; end n_vec++;
        if (fwd_stall !== 1'b0) begin $display("FAIL merge_hit_stall: got %b want 0", fwd_stall); n_err++; end n_vec++;
        if (fwd_data !== 32'hCC00_BBAA) begin $display("FAIL merge_data: got %h want cc00bbaa", fwd_data); n_err++; end n_vec++;
        ld_strb = 4'h4;
        #1;
        if ({fwd_hit, fwd_stall} !== 2'b00) begin $display("FAIL merge_nolane: got %b want 00", {fwd_hit, fwd_stall}); n_err++; end n_vec++;
        ld_valid = 1'b0; ld_strb = 4'hB;
        #1;
        if ({fwd_hit, fwd_stall} !== 2'b00) begin $display("FAIL merge_ldinvalid: got %b want 00", {fwd_hit, fwd_stall}); n_err++; end n_vec++;
        drain_all();
    endtask

    task automatic test_back_to_back();
        push(32'h400, 32'h1000, 4'hF);
        push(32'h404, 32'h1001, 4'hF);
        for (int k = 0; k < 5; k++) begin
            bus_wready = 1'b1;
            tick();
            bus_wready = 1'b0;
            bus_bvalid = 1'b1;
            commit_valid = 1'b1;
            commit_addr  = 32'h400 + 32'(4 * (k + 2));
            commit_data  = 32'h1000 + 32'(k + 2);
            commit_strb  = 4'hF;
            tick();
            bus_bvalid = 1'b0; commit_valid = 1'b0;
            if (sq_count !== 3'd2) begin $display("FAIL b2b_count: got %0d want 2", sq_count); n_err++; end n_vec++;
            tick();
            if (bus_awaddr !== 32'h400 + 32'(4 * (k + 1))) begin $display("FAIL b2b_head: got %h want %h", bus_awaddr, 32'h400 + 32'(4 * (k + 1))); n_err++; end n_vec++;
        end
        if (bus_wdata !== 32'h1005) begin $display("FAIL b2b_wdata: got %h want 1005", bus_wdata); n_err++; end n_vec++;
        ld_valid = 1'b1; ld_addr = 32'h418; ld_strb = 4'hF;
        #1;
        if (fwd_hit !== 1'b1) begin $display("FAIL b2b_fwd_hit: got %b want 1", fwd_hit); n_err++; end n_vec++;
        if (fwd_data !== 32'h1006) begin $display("FAIL b2b_fwd_data: got %h want 1006", fwd_data); n_err++; end n_vec++;
        ld_valid = 1'b0;
        drain_all();
    endtask

    task automatic test_reset_in_flight();
        push(32'h500, 32'h5, 4'hF);
        push(32'h504, 32'h6, 4'hF);
        push(32'h508, 32'h7, 4'hF);
        bus_wready = 1'b1;
        tick();
        bus_wready = 1'b0;
        if (sq_count !== 3'd3) begin $display("FAIL rif_pre_count: got %0d want 3", sq_count); n_err++; end n_vec++;
        reset = 1'b1;
        tick();
        if (sq_count !== 3'd0) begin $display("FAIL rif_count: got %0d want 0", sq_count); n_err++; end n_vec++;
        if (sq_empty !== 1'b1) begin $display("FAIL rif_empty: got %b want 1", sq_empty); n_err++; end n_vec++;
        if (commit_ready !== 1'b1) begin $display("FAIL rif_ready: got %b want 1", commit_ready); n_err++; end n_vec++;
        if (bus_awvalid !== 1'b0) begin $display("FAIL rif_awvalid: got %b want 0", bus_awvalid); n_err++; end n_vec++;
        if (bus_awaddr !== 32'h0) begin $display("FAIL rif_awaddr: got %h want 0", bus_awaddr); n_err++; end n_vec++;
        ld_valid = 1'b1; ld_addr = 32'h500; ld_strb = 4'hF;
        #1;
        if ({fwd_hit, fwd_stall} !== 2'b00) begin $display("FAIL rif_fwd: got %b want 00", {fwd_hit, fwd_stall}); n_err++; end n_vec++;
        if (fwd_data !== 32'h0) begin $display("FAIL rif_fwd_data: got %h want 0", fwd_data); n_err++; end n_vec++;
        reset = 1'b0; ld_valid = 1'b0;
        bus_bvalid = 1'b1;
        tick(); tick();
        bus_bvalid = 1'b0;
        if (sq_count !== 3'd0) begin $display("FAIL rif_late_bvalid: got %0d want 0", sq_count); n_err++; end n_vec++;
        if (bus_awvalid !== 1'b0) begin $display("FAIL rif_late_awvalid: got %b want 0", bus_awvalid); n_err++; end n_vec++;
        push(32'h600, 32'h66, 4'h3);
        tick();
        if (bus_awaddr !== 32'h600) begin $display("FAIL rif_restart_addr: got %h want 600", bus_awaddr); n_err++; end n_vec++;
        if (bus_wstrb !== 4'h3) begin $display("FAIL rif_restart_strb: got %h want 3", bus_wstrb); n_err++; end n_vec++;
        drain_all();
    endtask

    initial begin
        test_reset();
        test_single_store();
        test_full();
        test_fwd_youngest();
        test_fwd_merge();
        test_back_to_back();
        test_reset_in_flight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/ysyx_lsu_sq.md
# ysyx_lsu_sq

Parametrised store queue with byte-granular store-to-load forwarding and a single-outstanding write-drain engine. It sits between the reorder unit's store-commit port and the LSU bus write channel, and replaces the fixed, full-word-match store buffer. The load path uses it to forward merged bytes from all pending stores. Fence logic uses it to detect when all committed stores are globally performed.

## Interface

Parameters:
- SQ_SIZE, default 4: entry count; power of two, ≥2.
- XLEN, default 32: address/data width; XLEN/8 byte lanes.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- commit_valid  in  1  committed store offered.
- commit_ready  out  1  queue can accept (not full).
- commit_addr  in  XLEN  store byte address; word-aligned lanes selected by strb.
- commit_data  in  XLEN  lane-aligned store data.
- commit_strb  in  XLEN/8  byte-lane enable.
- ld_valid  in  1  load lookup active.
- ld_addr  in  XLEN  load address; compared on bits [XLEN-1:2].
- ld_strb  in  XLEN/8  lanes the load needs.
- fwd_hit  out  1  all needed lanes supplied by queue.
- fwd_stall  out  1  some but not all needed lanes supplied.
- fwd_data  out  XLEN  merged forwarded bytes (lane-aligned).
- bus_awvalid  out  1  write request valid.
- bus_awaddr  out  XLEN  head entry address.
- bus_wdata  out  XLEN  head entry data.
- bus_wstrb  out  XLEN/8  head entry strobe.
- bus_wready  in  1  bus accepts request.
- bus_bvalid  in  1  write response.
- sq_empty  out  1  no valid entries and drain FSM idle.
- sq_count  out  $clog2(SQ_SIZE)+1  valid entry count.

## Operation

- Circular buffer, head/tail pointers of $clog2(SQ_SIZE) bits, wrap naturally. Separate count register disambiguates full/empty.
- Enqueue when commit_valid && commit_ready. Writes addr/data/strb at tail, tail+1, count+1.
- commit_ready = (count != SQ_SIZE). Uses registered count only; a same-cycle pop does not free a slot for a full queue.
- Drain FSM:
  - IDLE: count≠0 → REQ.
  - REQ: bus_awvalid=1 with head fields held stable; bus_wready → RESP.
  - RESP: bus_bvalid → pop head (head+1, count−1) and go to IDLE. A bvalid seen in IDLE/REQ is ignored.
- Simultaneous enqueue and pop: count unchanged; both pointers advance.
- Forwarding is combinational over all valid entries, including the head in flight.
  - Per lane, the youngest matching entry with strb set supplies the byte.
  - covered = OR of supplying lanes & ld_strb.
  - fwd_hit = ld_valid && covered==ld_strb && ld_strb≠0.
  - fwd_stall = ld_valid && covered≠0 && covered≠ld_strb.
  - Uncovered lanes of fwd_data are 0.
- No pipeline-flush input: committed stores are never discarded. Reset clears everything, including an in-flight write; the bus side must tolerate this.

## Timing

- Reset values: commit_ready=1, sq_empty=1, sq_count=0, bus_awvalid=0, bus_awaddr/wdata/wstrb=0, fwd_hit=fwd_stall=0, FSM=IDLE, head=tail=0.
- An enqueued store is visible to forwarding and sq_count the next cycle.
- Store drain latency from enqueue into an empty queue:
  - bus_awvalid asserts 2 cycles after the enqueue edge (entry valid, then IDLE→REQ).
  - Best-case throughput is 1 store per 3 cycles (IDLE, REQ with wready, RESP with bvalid).
- bus_awvalid, once high, stays high until bus_wready, with stable address, data and strobe.
- sq_empty drops the cycle after the first enqueue. It rises the cycle after the final pop.
- Forward outputs have zero latency from ld_* inputs.

## Structure

- Drain state enum (IDLE/REQ/RESP) goes in the shared ysyx package header alongside the existing LSU state types. No new global defines; SQ_SIZE default comes from the existing queue-size define.
- One natural sub-module: ysyx_lsu_sq_fwd, a combinational age-ordered per-lane merge. Inputs: entry arrays, valid vector, head pointer, ld_addr/ld_strb. Outputs: fwd_data/covered.

## Test plan

- Reset, then one SW to 0x8000_0010 with data 0xDEADBEEF and strb 0xF. Expect sq_count=1 next cycle and awvalid 2 cycles after enqueue. With wready and bvalid each 1 cycle, expect sq_empty=1 three cycles later.
- Fill 4 entries with wready held 0. Expect commit_ready=0 and further commit_valid ignored. Then pulse wready/bvalid: commit_ready=1 the cycle after the pop.
- Store 0x11 to lane 0 (addr 0x100), then 0x22 to lane 0, then LW 0x100 with ld_strb=0x1. Expect fwd_hit=1 and fwd_data[7:0]=0x22.
- Store SH 0xBBAA at lanes 0-1 and SB 0xCC at lane 3 of 0x200, then load with ld_strb=0xF. Expect fwd_stall=1. Load with ld_strb=0xB: expect fwd_hit=1 and fwd_data=0xCC00BBAA.
- Enqueue on the same cycle as a head pop with count=2: expect count stays 2 and pointer wrap is correct after 5 such cycles.
- Assert reset while in RESP with 3 entries: expect all reset values next cycle, and a later bvalid is ignored.
